pc_fetch_unit: RTL and testbench

- Program-counter stage directly upstream of the instruction memory.
- Holds the architectural PC and drives it as the instruction-memory fetch address.
- Computes next PC from sequential, branch (beq) and jump control inputs; supports stall, halt request and out-of-range fault.
- Counts retired (advanced) instructions for the testbench and $display traces.

---
 rtl/pc_fetch_unit_pkg.sv | 14 +
 rtl/pc_next_logic.sv | 42 ++++
 rtl/pc_fetch_unit.sv | 72 +++++++
 tb/tb_pc_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the program-counter fetch stage:
// state encoding, reset address and the word-to-byte shift.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam int          WORD_SHIFT        = 2;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: jump beats branch beats sequential,
// then flags any candidate that falls outside the instruction-memory window.
module pc_next_logic
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEFAULT,
  parameter int          TEXT_WORDS = 256
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] candidate,
  output logic        out_of_range
);

  // 33-bit bounds so a window ending exactly at 2^32 still compares correctly
  localparam logic [32:0] LO_BOUND = {1'b0, TEXT_BASE};
  localparam logic [32:0] HI_BOUND = LO_BOUND + 33'(TEXT_WORDS) * 33'd4;

  logic [31:0] seq;
  logic [31:0] btgt;
  logic [31:0] jtgt;

  always_comb begin
    seq  = pc + 32'd4;
    btgt = seq + (branch_offset << WORD_SHIFT);
    jtgt = {seq[31:28], jump_index, 2'b00};

    if (jump) begin
      candidate = jtgt;
    end else if (branch_taken) begin
      candidate = btgt;
    end else begin
      candidate = seq;
    end

    out_of_range = ({1'b0, candidate} < LO_BOUND) || ({1'b0, candidate} >= HI_BOUND);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the fetch address, a RUN/HALTED/FAULT state
// and a saturating count of retired PC advances.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEFAULT,
  parameter int          TEXT_WORDS = 256,
  parameter int          CNT_W      = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t state;
  logic [31:0]  candidate;
  logic         out_of_range;

  assign pc_plus4 = pc + 32'd4;

  pc_next_logic #(
    .TEXT_BASE (TEXT_BASE),
    .TEXT_WORDS(TEXT_WORDS)
  ) u_next (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .candidate    (candidate),
    .out_of_range (out_of_range)
  );

  // Only RUN advances; halted/fault are registered alongside the state
  always_ff @(posedge clock) begin
    if (clear) begin
      pc           <= TEXT_BASE;
      state        <= RUN;
      retire_count <= '0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else if (state == RUN) begin
      if (halt_req) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else if (!stall) begin
        if (out_of_range) begin
          state <= FAULT;
          fault <= 1'b1;
        end else begin
          pc <= candidate;
          if (retire_count != '1) begin
            retire_count <= retire_count + CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios plus random traffic,
// checked against an arithmetic reference model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] BASE     = 32'h0040_0000;
  localparam int          WORDS    = 256;
  localparam int          TB_CNT_W = 6;
  localparam longint      CNT_MAX  = (64'd1 << TB_CNT_W) - 1;

  logic                clock;
  logic                clear;
  logic                stall;
  logic                branch_taken;
  logic [31:0]         branch_offset;
  logic                jump;
  logic [25:0]         jump_index;
  logic                halt_req;
  logic [31:0]         pc;
  logic [31:0]         pc_plus4;
  logic                halted;
  logic                fault;
  logic [TB_CNT_W-1:0] retire_count;

  typedef struct {
    logic [31:0]         pc;
    logic                halted;
    logic                fault;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   totalCount = 0;
  int   badCount   = 0;

  logic [31:0] mPc;
  logic        mHalted;
  logic        mFault;
  longint      mCnt;

  pc_fetch_unit #(
    .TEXT_BASE (BASE),
    .TEXT_WORDS(WORDS),
    .CNT_W     (TB_CNT_W)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .halt_req     (halt_req),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .fault        (fault),
    .retire_count (retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs and push the model's post-edge expectation
  task automatic applyStimulus(input logic clr, input logic stl, input logic bt,
                               input logic [31:0] boff, input logic j,
                               input logic [25:0] jidx, input logic hr);
    longint tgt;
    exp_t   e;
    @(negedge clock);
    clear         = clr;
    stall         = stl;
    branch_taken  = bt;
    branch_offset = boff;
    jump          = j;
    jump_index    = jidx;
    halt_req      = hr;
    if (clr) begin
      mPc = BASE; mHalted = 1'b0; mFault = 1'b0; mCnt = 0;
    end else if (!mHalted && !mFault) begin
      if (hr) begin
        mHalted = 1'b1;
      end else if (!stl) begin
        if (j)
          tgt = ((longint'(mPc) + 4) & 64'hF000_0000) | (longint'(jidx) * 4);
        else if (bt)
          tgt = (longint'(mPc) + 4 + longint'($signed(boff)) * 4) & 64'hFFFF_FFFF;
        else
          tgt = (longint'(mPc) + 4) & 64'hFFFF_FFFF;
        if (tgt < longint'(BASE) || tgt >= longint'(BASE) + 4 * WORDS) begin
          mFault = 1'b1;
        end else begin
          mPc = tgt[31:0];
          if (mCnt < CNT_MAX) mCnt = mCnt + 1;
        end
      end
    end
    e.pc     = mPc;
    e.halted = mHalted;
    e.fault  = mFault;
    e.cnt    = mCnt[TB_CNT_W-1:0];
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] expPlus4;
    expPlus4 = e.pc + 32'd4;
    totalCount++;
    if (pc !== e.pc) begin
      badCount++;
      $display("[TB] FAIL pc: got %h want %h", pc, e.pc);
    end
    totalCount++;
    if (pc_plus4 !== expPlus4) begin
      badCount++;
      $display("[TB] FAIL pc_plus4: got %h want %h", pc_plus4, expPlus4);
    end
    totalCount++;
    if (halted !== e.halted) begin
      badCount++;
      $display("[TB] FAIL halted: got %b want %b (pc %h)", halted, e.halted, e.pc);
    end
    totalCount++;
    if (fault !== e.fault) begin
      badCount++;
      $display("[TB] FAIL fault: got %b want %b (pc %h)", fault, e.fault, e.pc);
    end
    totalCount++;
    if (retire_count !== e.cnt) begin
      badCount++;
      $display("[TB] FAIL retire_count: got %0d want %0d", retire_count, e.cnt);
    end
  endtask

  // Monitor: the DUT presents a new output after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic freeCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF, 1'b1);
  endtask

  initial begin
    int drain;
    clear = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_index = '0; halt_req = 1'b0;
    mPc = BASE; mHalted = 1'b0; mFault = 1'b0; mCnt = 0;

    $display("[TB] reset and sequential fetch");
    doClear();
    repeat (6) freeCycle();

    $display("[TB] backward branch from 00400018");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9, 1'b0, 26'd0, 1'b0);

    $display("[TB] jump beats branch");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 26'h010_0004, 1'b0);

    $display("[TB] stall then halt");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 26'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'h010_0020, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 26'd0, 1'b0);
    doClear();

    $display("[TB] branch range boundary");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 26'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0);
    repeat (2) freeCycle();
    doClear();

    $display("[TB] sequential fall-through past last word");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h010_00FF, 1'b0);
    freeCycle();
    freeCycle();
    doClear();

    $display("[TB] long sequential run to counter saturation");
    repeat (80) freeCycle();
    doClear();

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      int off;
      logic clr;
      off = int'($urandom_range(0, 40)) - 20;
      clr = ($urandom_range(0, 199) == 0) ||
            ((mHalted || mFault) && $urandom_range(0, 7) == 0);
      applyStimulus(clr,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 7) == 0,
                    off,
                    $urandom_range(0, 15) == 0,
                    26'(32'h0010_0000 + $urandom_range(0, 300)),
                    $urandom_range(0, 149) == 0);
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clock);
      drain++;
    end
    #2;
    if (sb.size() > 0) begin
      badCount++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
